multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 i_opcode  input  6  instruction opcode from the held instruction register; stable from DECODE to end of instruction.
REQ-004 i_zero  input  1  ALU zero flag; used only in BRANCH.
REQ-005 i_mem_ready  input  1  memory handshake; access completes in a cycle where it is 1.
REQ-006 o_pc_en  output  1  PC register write enable.
REQ-007 o_i_or_d  output  1  memory address mux select (0=PC, 1=ALUOut).
REQ-008 o_mem_read  output  1  memory read strobe.
REQ-009 o_mem_write  output  1  memory write strobe.
REQ-010 o_ir_write  output  1  instruction register load enable.
REQ-011 o_reg_dst  output  1  write-register mux select (0=rt, 1=rd).
REQ-012 o_mem_to_reg  output  1  write-data mux select (0=ALUOut, 1=MDR).
REQ-013 o_reg_write  output  1  register file write enable.
REQ-014 o_alu_src_a  output  1  ALU A mux select (0=PC, 1=rs data).
REQ-015 o_alu_src_b  output  2  ALU B select (00=rt data, 01=const 4, 10=sign-ext imm, 11=imm<<2).
REQ-016 o_alu_op  output  2  ALU op class (00=add, 01=sub, 10=funct-decoded).
REQ-017 o_pc_source  output  2  PC mux select (00=ALU result, 01=ALUOut, 10=jump target).
REQ-018 o_state  output  4  current state encoding, for debug.
REQ-019 o_illegal  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-020 States and codes SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-021 Outputs SHALL be combinational decodes of the state (Mealy only where noted); every output not listed for a state SHALL be 0.
REQ-022 FETCH SHALL assert o_mem_read, o_i_or_d=0, o_alu_src_b=01, o_alu_op=00, o_pc_source=00; o_ir_write=o_pc_en=i_mem_ready; advance to DECODE only when i_mem_ready=1, else hold.
REQ-023 DECODE SHALL drive o_alu_src_b=11, o_alu_op=00; next state by i_opcode: 0x23/0x2B->MEMADR, 0x00->EXEC, 0x04->BRANCH, 0x02->JUMP, 0x08->ADDIEX (macro only), any other->FETCH with o_illegal=1 that cycle.
REQ-024 MEMADR SHALL drive o_alu_src_a=1, o_alu_src_b=10, o_alu_op=00; next: 0x23->MEMRD, else MEMWR.
REQ-025 MEMRD SHALL assert o_mem_read, o_i_or_d=1; hold until i_mem_ready=1, then MEMWB.
REQ-026 MEMWB SHALL assert o_reg_write, o_mem_to_reg=1, o_reg_dst=0; next FETCH.
REQ-027 MEMWR SHALL assert o_mem_write, o_i_or_d=1; hold until i_mem_ready=1, then FETCH; strobe stays 1 while waiting.
REQ-028 EXEC SHALL drive o_alu_src_a=1, o_alu_src_b=00, o_alu_op=10; next ALUWB, which asserts o_reg_write, o_reg_dst=1, o_mem_to_reg=0, then FETCH.
REQ-029 BRANCH SHALL drive o_alu_src_a=1, o_alu_src_b=00, o_alu_op=01, o_pc_source=01, o_pc_en=i_zero (Mealy); next FETCH.
REQ-030 JUMP SHALL drive o_pc_source=10, o_pc_en=1; next FETCH.
REQ-031 Unreachable state codes 12-15 SHALL go to FETCH next cycle with all outputs 0.

Reset
REQ-032 reset=1 SHALL force state to FETCH immediately, regardless of clk.
REQ-033 While reset=1 all outputs SHALL be 0 (o_state=0); first FETCH access begins on the first rising edge after release.

Configuration
REQ-034 With macro MULTICYCLE_CTRL_ADDI_EN defined, opcode 0x08 SHALL run ADDIEX (o_alu_src_a=1, o_alu_src_b=10, o_alu_op=00) then ADDIWB (o_reg_write, o_reg_dst=0, o_mem_to_reg=0), then FETCH.
REQ-035 Without the macro, states 10/11 SHALL not exist and 0x08 SHALL be illegal per REQ-023.

Verification
REQ-036 lw (0x23), i_mem_ready=1 always -> o_state 0,1,2,3,4,0; o_reg_write=1 with o_mem_to_reg=1 only in 5th cycle.
REQ-037 sw (0x2B), i_mem_ready=0 for 3 cycles in MEMWR -> state 5 held 4 cycles with o_mem_write=1, then 0.
REQ-038 beq (0x04), i_zero=1 -> in state 8 o_pc_en=1, o_pc_source=01; repeat with i_zero=0 -> o_pc_en=0.
REQ-039 opcode 0x3F -> state 1 then 0, o_illegal=1 for exactly one cycle; 0x08 same without macro, states 0,1,10,11,0 with macro.
REQ-040 reset pulsed mid-MEMRD between edges -> o_state=0 and all outputs 0 at once; normal FETCH after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU main control FSM
//
// Purpose: sequences FETCH/DECODE/execute/write-back for lw, sw, R-type, beq, j
// and (optionally) addi, emitting datapath mux selects and strobes each state.
// Optional feature macro: MULTICYCLE_CTRL_ADDI_EN (adds ADDIEX/ADDIWB for 0x08).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   i_opcode[5:0]         held instruction opcode
//   i_zero                ALU zero flag (branch decision)
//   i_mem_ready           memory access completes when 1
//   o_pc_en, o_pc_source  PC write enable / PC mux select
//   o_i_or_d              memory address select (0=PC, 1=ALUOut)
//   o_mem_read/_write     memory strobes
//   o_ir_write            instruction register load
//   o_reg_dst, o_mem_to_reg, o_reg_write   register file write controls
//   o_alu_src_a/_b, o_alu_op              ALU operand and op-class selects
//   o_state[3:0]          current state (debug)
//   o_illegal             one-cycle pulse on unsupported opcode in DECODE

module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_en,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic [3:0] o_state,
  output logic       o_illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef MULTICYCLE_CTRL_ADDI_EN
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [5:0] OP_ADDI  = 6'h08;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = i_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = i_mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode; FETCH and BRANCH carry Mealy terms
  always_comb begin
    o_pc_en      = 1'b0;
    o_i_or_d     = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_pc_source  = 2'b00;
    o_illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        o_ir_write  = i_mem_ready;
        o_pc_en     = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_b = 2'b11;
        case (i_opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: o_illegal = 1'b0;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:                             o_illegal = 1'b0;
`endif
          default:                             o_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b01;
        o_pc_source = 2'b01;
        o_pc_en     = i_zero;
      end
      S_JUMP: begin
        o_pc_source = 2'b10;
        o_pc_en     = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        o_reg_write = 1'b1;
      end
`endif
      default: ;
    endcase
    // State is already FETCH under reset, but FETCH's strobes must stay quiet
    // until the first edge after release.
    if (reset) begin
      o_pc_en      = 1'b0;
      o_mem_read   = 1'b0;
      o_ir_write   = 1'b0;
      o_alu_src_b  = 2'b00;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] i_opcode;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_pc_en, o_i_or_d, o_mem_read, o_mem_write, o_ir_write;
  logic       o_reg_dst, o_mem_to_reg, o_reg_write, o_alu_src_a, o_illegal;
  logic [1:0] o_alu_src_b, o_alu_op, o_pc_source;
  logic [3:0] o_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Packed view: pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,
  // reg_write,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_source[1:0],illegal
  logic [15:0] outs;
  assign outs = {o_pc_en, o_i_or_d, o_mem_read, o_mem_write, o_ir_write,
                 o_reg_dst, o_mem_to_reg, o_reg_write, o_alu_src_a,
                 o_alu_src_b, o_alu_op, o_pc_source, o_illegal};

  multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_opcode     (i_opcode),
    .i_zero       (i_zero),
    .i_mem_ready  (i_mem_ready),
    .o_pc_en      (o_pc_en),
    .o_i_or_d     (o_i_or_d),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_ir_write   (o_ir_write),
    .o_reg_dst    (o_reg_dst),
    .o_mem_to_reg (o_mem_to_reg),
    .o_reg_write  (o_reg_write),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_op     (o_alu_op),
    .o_pc_source  (o_pc_source),
    .o_state      (o_state),
    .o_illegal    (o_illegal)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset       = 1'b1;
    i_opcode    = 6'h00;
    i_zero      = 1'b0;
    i_mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (o_state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d exp 0", o_state);
    end
    n_cmp++;
    if (outs !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outs got %h exp 0000", outs);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [15:0] eo [6] = '{16'hA820, 16'h0060, 16'h00C0, 16'h6000, 16'h0300, 16'hA820};
    i_opcode = 6'h23;
    i_mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (o_state !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL lw cyc%0d state %0d outs %h exp state %0d outs %h", i, o_state, outs, es[i], eo[i]);
      end
      if (i != 5) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  es [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic [15:0] eo [8] = '{16'hA820, 16'h0060, 16'h00C0, 16'h5000, 16'h5000, 16'h5000, 16'h5000, 16'hA820};
    logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    i_opcode = 6'h2B;
    for (int i = 0; i < 8; i++) begin
      i_mem_ready = rd[i];
      #1;
      n_cmp++;
      if (o_state !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL sw_wait cyc%0d state %0d outs %h exp state %0d outs %h", i, o_state, outs, es[i], eo[i]);
      end
      if (i != 7) begin @(posedge clk); #1; end
    end
    i_mem_ready = 1'b1;
  endtask

  task automatic test_beq(input logic zero, input logic [15:0] br_outs);
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [15:0] eo [4];
    eo = '{16'hA820, 16'h0060, br_outs, 16'hA820};
    i_opcode = 6'h04;
    i_zero   = zero;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (o_state !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL beq_z%0d cyc%0d state %0d outs %h exp state %0d outs %h", zero, i, o_state, outs, es[i], eo[i]);
      end
      if (i != 3) begin @(posedge clk); #1; end
    end
    i_zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    logic [15:0] eo [4] = '{16'hA820, 16'h0060, 16'h8004, 16'hA820};
    i_opcode = 6'h02;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (o_state !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL jump cyc%0d state %0d outs %h exp state %0d outs %h", i, o_state, outs, es[i], eo[i]);
      end
      if (i != 3) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [15:0] eo [5] = '{16'hA820, 16'h0060, 16'h0090, 16'h0500, 16'hA820};
    i_opcode = 6'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (o_state !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL rtype cyc%0d state %0d outs %h exp state %0d outs %h", i, o_state, outs, es[i], eo[i]);
      end
      if (i != 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd0};
    logic [15:0] eo [3] = '{16'hA820, 16'h0061, 16'hA820};
    i_opcode = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (o_state !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL illegal cyc%0d state %0d outs %h exp state %0d outs %h", i, o_state, outs, es[i], eo[i]);
      end
      if (i != 2) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_addi();
`ifdef MULTICYCLE_CTRL_ADDI_EN
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    logic [15:0] eo [5] = '{16'hA820, 16'h0060, 16'h00C0, 16'h0100, 16'hA820};
    int n = 5;
`else
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
    logic [15:0] eo [5] = '{16'hA820, 16'h0061, 16'hA820, 16'h0000, 16'h0000};
    int n = 3;
`endif
    i_opcode = 6'h08;
    for (int i = 0; i < n; i++) begin
      #1;
      n_cmp++;
      if (o_state !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL addi cyc%0d state %0d outs %h exp state %0d outs %h", i, o_state, outs, es[i], eo[i]);
      end
      if (i != n - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_fetch_wait();
    logic [3:0]  es [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd9, 4'd0};
    logic [15:0] eo [6] = '{16'h2020, 16'h2020, 16'hA820, 16'h0060, 16'h8004, 16'hA820};
    logic        rd [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    i_opcode = 6'h02;
    for (int i = 0; i < 6; i++) begin
      i_mem_ready = rd[i];
      #1;
      n_cmp++;
      if (o_state !== es[i] || outs !== eo[i]) begin
        n_fail++;
        $display("FAIL fetch_wait cyc%0d state %0d outs %h exp state %0d outs %h", i, o_state, outs, es[i], eo[i]);
      end
      if (i != 5) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_memrd();
    i_opcode    = 6'h23;
    i_mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    i_mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (o_state !== 4'd3 || outs !== 16'h6000) begin
      n_fail++;
      $display("FAIL rst_memrd_pre state %0d outs %h exp state 3 outs 6000", o_state, outs);
    end
    #2;
    i_mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (o_state !== 4'd0 || outs !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_memrd_async state %0d outs %h exp state 0 outs 0000", o_state, outs);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_state !== 4'd0 || outs !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_memrd_held state %0d outs %h exp state 0 outs 0000", o_state, outs);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (o_state !== 4'd0 || outs !== 16'hA820) begin
      n_fail++;
      $display("FAIL rst_memrd_release state %0d outs %h exp state 0 outs a820", o_state, outs);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_state !== 4'd1 || outs !== 16'h0060) begin
      n_fail++;
      $display("FAIL rst_memrd_decode state %0d outs %h exp state 1 outs 0060", o_state, outs);
    end
    // finish the lw so later tests start in FETCH
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++;
    if (o_state !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_memrd_done state %0d exp 0", o_state);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq(1'b1, 16'h808A);
    test_beq(1'b0, 16'h008A);
    test_jump();
    test_rtype();
    test_illegal();
    test_addi();
    test_fetch_wait();
    test_reset_mid_memrd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
